// File: rtl/sample_channel_sequencer.sv
// sample_channel_sequencer: steps through channel slots and sample positions,
// settling after each channel select and strobing one shift per captured sample.
module sample_channel_sequencer #(
   parameter int NUM_CHANNELS      = 14,
   parameter int SAMPLES_PER_FRAME = 10,
   parameter int SETTLE_CYCLES     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       continuous,
   input  logic       sample_valid,
   output logic [3:0] ch_sel,
   output logic [3:0] sample_idx,
   output logic       shift_en,
   output logic       frame_done,
   output logic       busy,
   output logic       overrun
);

   localparam logic [3:0] LP_CH_LAST  = 4'(NUM_CHANNELS - 1);
   localparam logic [3:0] LP_IDX_LAST = 4'(SAMPLES_PER_FRAME - 1);
   localparam logic [3:0] LP_SETTLE   = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_NEXT
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_settle_cnt;
   logic [3:0] w_settle_cnt_nxt;
   logic       r_stop_pend;
   logic       w_stop_pend_nxt;
   logic [3:0] r_ch;
   logic [3:0] w_ch_nxt;
   logic [3:0] r_idx;
   logic [3:0] w_idx_nxt;
   logic       r_shift;
   logic       w_shift_nxt;
   logic       r_fd;
   logic       w_fd_nxt;
   logic       r_busy;
   logic       w_busy_nxt;
   logic       r_ovr;
   logic       w_ovr_nxt;
   logic       w_last_ch;
   logic       w_last_idx;
   logic       w_term;

   assign w_last_ch  = (r_ch == LP_CH_LAST);
   assign w_last_idx = (r_idx == LP_IDX_LAST);

   // Next-state and next-output decode; outputs are registered from these.
   always_comb begin
      w_state_nxt      = r_state;
      w_settle_cnt_nxt = r_settle_cnt;
      w_stop_pend_nxt  = r_stop_pend;
      w_ch_nxt         = r_ch;
      w_idx_nxt        = r_idx;
      w_ovr_nxt        = r_ovr;
      w_shift_nxt      = 1'b0;
      w_fd_nxt         = 1'b0;
      w_term           = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state_nxt      = S_SETTLE;
               w_ch_nxt         = 4'd0;
               w_idx_nxt        = 4'd0;
               w_settle_cnt_nxt = LP_SETTLE;
               w_ovr_nxt        = 1'b0;
               w_stop_pend_nxt  = 1'b0;
            end
         end
         S_SETTLE: begin
            if (stop) w_stop_pend_nxt = 1'b1;
            if (sample_valid) w_ovr_nxt = 1'b1;
            if (r_settle_cnt <= 4'd1) begin
               w_state_nxt      = S_CAPTURE;
               w_settle_cnt_nxt = 4'd0;
            end else begin
               w_settle_cnt_nxt = r_settle_cnt - 4'd1;
            end
         end
         S_CAPTURE: begin
            if (stop) w_stop_pend_nxt = 1'b1;
            if (sample_valid) begin
               w_state_nxt = S_NEXT;
               w_shift_nxt = 1'b1;
               w_fd_nxt    = w_last_ch && w_last_idx;
            end
         end
         S_NEXT: begin
            if (sample_valid) w_ovr_nxt = 1'b1;
            if (!w_last_ch) begin
               w_ch_nxt = r_ch + 4'd1;
            end else begin
               w_ch_nxt = 4'd0;
               if (w_last_idx) w_idx_nxt = 4'd0;
               else            w_idx_nxt = r_idx + 4'd1;
            end
            // a stop seen in this very cycle still ends the run here
            w_term = r_stop_pend || stop || (r_fd && !continuous);
            if (w_term) begin
               w_state_nxt      = S_IDLE;
               w_stop_pend_nxt  = 1'b0;
               w_settle_cnt_nxt = 4'd0;
            end else begin
               w_state_nxt      = S_SETTLE;
               w_settle_cnt_nxt = LP_SETTLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State, counters and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_settle_cnt <= 4'd0;
         r_stop_pend  <= 1'b0;
         r_ch         <= 4'd0;
         r_idx        <= 4'd0;
         r_shift      <= 1'b0;
         r_fd         <= 1'b0;
         r_busy       <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_cnt_nxt;
         r_stop_pend  <= w_stop_pend_nxt;
         r_ch         <= w_ch_nxt;
         r_idx        <= w_idx_nxt;
         r_shift      <= w_shift_nxt;
         r_fd         <= w_fd_nxt;
         r_busy       <= w_busy_nxt;
         r_ovr        <= w_ovr_nxt;
      end
   end

   assign ch_sel     = r_ch;
   assign sample_idx = r_idx;
   assign shift_en   = r_shift;
   assign frame_done = r_fd;
   assign busy       = r_busy;
   assign overrun    = r_ovr;

endmodule

// File: tb/tb_sample_channel_sequencer.sv
// tb_sample_channel_sequencer: directed runs with an expected-strobe queue
// and a monitor that checks every shift_en against it.
module tb_sample_channel_sequencer;

   typedef struct {
      int cyc;
      int ch;
      int idx;
      int fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       continuous = 1'b0;
   logic       sample_valid = 1'b0;
   logic [3:0] ch_sel;
   logic [3:0] sample_idx;
   logic       shift_en;
   logic       frame_done;
   logic       busy;
   logic       overrun;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];

   sample_channel_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .continuous   (continuous),
      .sample_valid (sample_valid),
      .ch_sel       (ch_sel),
      .sample_idx   (sample_idx),
      .shift_en     (shift_en),
      .frame_done   (frame_done),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (shift_en) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_shift: cyc=%0d ch=%0d idx=%0d, none required",
                     cyc, ch_sel, sample_idx);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc || e.ch != int'(ch_sel) ||
                e.idx != int'(sample_idx) || e.fd != int'(frame_done)) begin
               n_err++;
               $display("FAIL strobe: got cyc=%0d ch=%0d idx=%0d fd=%0d, expected cyc=%0d ch=%0d idx=%0d fd=%0d",
                        cyc, ch_sel, sample_idx, frame_done, e.cyc, e.ch, e.idx, e.fd);
            end
         end
      end else if (frame_done) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_done_alone: cyc=%0d got 1 expected 0", cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input int ch, input int idx, input int fd);
      exp_t e;
      e.cyc = c;
      e.ch  = ch;
      e.idx = idx;
      e.fd  = fd;
      q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int c0;
      int c1;
      tick();
      tick();
      tick();
      chk("rst_ch_sel", int'(ch_sel), 0);
      chk("rst_idx", int'(sample_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_shift", int'(shift_en), 0);
      reset = 1'b0;
      tick();

      // start with stop held: stays idle
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_idle", int'(busy), 0);
      tick();
      tick();
      chk("start_stop_idle2", int'(busy), 0);

      // single full frame, sample_valid held high
      sample_valid = 1'b1;
      continuous   = 1'b0;
      c0 = cyc;
      for (int k = 0; k < 140; k++)
         push(c0 + 5 * (k + 1), k % 14, k / 14, (k == 139) ? 1 : 0);
      pulse_start();
      chk("f1_busy_c1", int'(busy), 1);
      wait_until(c0 + 12);
      pulse_start();
      wait_until(c0 + 701);
      chk("f1_busy_end", int'(busy), 0);
      tick();
      tick();

      // continuous: second frame follows, stop in slot 142 settle
      continuous = 1'b1;
      c0 = cyc;
      for (int k = 0; k <= 142; k++)
         push(c0 + 5 * (k + 1), k % 14, (k / 14) % 10, ((k % 140) == 139) ? 1 : 0);
      pulse_start();
      wait_until(c0 + 703);
      chk("cont_busy_gap", int'(busy), 1);
      wait_until(c0 + 712);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      continuous = 1'b0;
      wait_until(c0 + 716);
      chk("cont_busy_end", int'(busy), 0);
      tick();
      tick();

      // stop during settle of ch 7
      c0 = cyc;
      for (int k = 0; k <= 7; k++) push(c0 + 5 * (k + 1), k, 0, 0);
      pulse_start();
      wait_until(c0 + 37);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_until(c0 + 41);
      chk("stop7_busy", int'(busy), 0);
      chk("stop7_fd", int'(frame_done), 0);
      wait_until(c0 + 70);
      chk("stop7_still_idle", int'(busy), 0);

      // sample_valid withheld 20 cycles in capture of ch 4
      c0 = cyc;
      for (int k = 0; k <= 3; k++) push(c0 + 5 * (k + 1), k, 0, 0);
      push(c0 + 45, 4, 0, 0);
      push(c0 + 50, 5, 0, 0);
      pulse_start();
      wait_until(c0 + 20);
      sample_valid = 1'b0;
      wait_until(c0 + 30);
      chk("wait_busy", int'(busy), 1);
      chk("wait_ch", int'(ch_sel), 4);
      wait_until(c0 + 44);
      sample_valid = 1'b1;
      wait_until(c0 + 47);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_until(c0 + 51);
      chk("wait_busy_end", int'(busy), 0);
      wait_until(c0 + 60);

      // overrun from a settle-time pulse, cleared by a new start
      sample_valid = 1'b0;
      c0 = cyc;
      push(c0 + 5, 0, 0, 0);
      push(c0 + 10, 1, 0, 0);
      pulse_start();
      wait_until(c0 + 2);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk("ovr_set", int'(overrun), 1);
      sample_valid = 1'b1;
      wait_until(c0 + 5);
      sample_valid = 1'b0;
      wait_until(c0 + 7);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_until(c0 + 9);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      wait_until(c0 + 12);
      chk("ovr_held_idle", int'(overrun), 1);
      chk("ovr_busy_end", int'(busy), 0);
      tick();
      c1 = cyc;
      push(c1 + 5, 0, 0, 0);
      pulse_start();
      chk("ovr_cleared", int'(overrun), 0);
      wait_until(c1 + 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_until(c1 + 4);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      wait_until(c1 + 7);
      chk("ovr_capture_clean", int'(overrun), 0);
      chk("ovr2_busy_end", int'(busy), 0);
      tick();

      // reset in capture of ch 9 with sample_valid high
      sample_valid = 1'b1;
      c0 = cyc;
      for (int k = 0; k <= 8; k++) push(c0 + 5 * (k + 1), k, 0, 0);
      pulse_start();
      wait_until(c0 + 49);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_ch", int'(ch_sel), 0);
      chk("mrst_idx", int'(sample_idx), 0);
      chk("mrst_shift", int'(shift_en), 0);
      chk("mrst_fd", int'(frame_done), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_ovr", int'(overrun), 0);
      wait_until(c0 + 70);
      chk("mrst_stay_idle", int'(busy), 0);
      sample_valid = 1'b0;
      tick();

      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
